// File: rtl/velseq_pkg.sv
// velseq_pkg: shared types, widths and the clamped slew step for velocity_sequencer.
// Latency: n/a (types and a combinational helper).
// Backpressure: n/a.
package velseq_pkg;

  localparam int VEL_W   = 8;
  localparam int DWELL_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_DWELL = 2'd2
`ifdef VELSEQ_ESTOP_EN
    ,
    ST_STOP  = 2'd3
`endif
  } state_e;

  // One slew step from vel toward tgt. The difference is taken at VEL_W+1 bits
  // so the 127 <-> -128 swing cannot wrap; when the remaining distance is
  // within one step the result lands exactly on the target.
  function automatic logic [VEL_W-1:0] next_vel(
    input logic [VEL_W-1:0] vel,
    input logic [VEL_W-1:0] tgt,
    input logic [VEL_W-1:0] step
  );
    logic signed [VEL_W:0] diff;
    logic        [VEL_W:0] mag;
    diff = $signed({tgt[VEL_W-1], tgt}) - $signed({vel[VEL_W-1], vel});
    mag  = diff[VEL_W] ? $unsigned(-diff) : $unsigned(diff);
    if (mag <= {1'b0, step}) begin
      return tgt;
    end else if (diff[VEL_W]) begin
      return vel - step;
    end else begin
      return vel + step;
    end
  endfunction

endpackage

// File: rtl/velocity_sequencer_tick_prescaler.sv
// tick_prescaler: free-running divider producing a one-cycle tick every TICK_DIV cycles.
// Latency: tick is high in the cycle the count equals TICK_DIV-1, then the count wraps.
// Backpressure: none; only reset clears the count.
module tick_prescaler #(
  parameter int TICK_DIV = 2604168
) (
  input  logic cclk,
  input  logic rstb,
  output logic tick
);

  localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  // Count register; wraps after the tick cycle.
  always_ff @(posedge cclk) begin
    if (!rstb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/velocity_sequencer.sv
// velocity_sequencer: accepts target velocities, slews output by STEP per tick, dwells, then pulses done.
// Latency: busy the cycle after acceptance; one step per TICK_DIV-cycle tick; ready the cycle after done.
// Backpressure: tgt_ready only in IDLE; tgt_valid while busy is ignored (no queueing).
// Optional feature macro: VELSEQ_ESTOP_EN adds the estop port and the STOP state.
module velocity_sequencer
  import velseq_pkg::*;
#(
  parameter int TICK_DIV = 2604168,
  parameter int STEP     = 1
) (
  input  logic               cclk,
  input  logic               rstb,
  input  logic [VEL_W-1:0]   tgt_vel,
  input  logic [DWELL_W-1:0] tgt_dwell,
  input  logic               tgt_valid,
`ifdef VELSEQ_ESTOP_EN
  input  logic               estop,
`endif
  output logic               tgt_ready,
  output logic [VEL_W-1:0]   velocity,
  output logic               at_target,
  output logic               busy,
  output logic               done
);

  localparam logic [VEL_W-1:0] STEP_V = VEL_W'(STEP);

  state_e             state_q;
  logic [VEL_W-1:0]   vel_q;
  logic [VEL_W-1:0]   tgt_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               at_target_q;
  logic               busy_q;
  logic               done_q;

  logic               tick;
  logic [VEL_W-1:0]   slew_tgt;
  logic [VEL_W-1:0]   vel_step_d;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .cclk (cclk),
    .rstb (rstb),
    .tick (tick)
  );

`ifdef VELSEQ_ESTOP_EN
  assign slew_tgt = (state_q == ST_STOP) ? '0 : tgt_q;
`else
  assign slew_tgt = tgt_q;
`endif

  assign vel_step_d = next_vel(vel_q, slew_tgt, STEP_V);

  assign tgt_ready = (state_q == ST_IDLE) & rstb;
  assign velocity  = vel_q;
  assign at_target = at_target_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Sequencer FSM with registered outputs; done is raised while still in
  // DWELL so that tgt_ready only rises in the cycle after the done pulse.
  always_ff @(posedge cclk) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      vel_q       <= '0;
      tgt_q       <= '0;
      dwell_q     <= '0;
      at_target_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
`ifdef VELSEQ_ESTOP_EN
      if (estop) begin
        // Abort whatever is running; slewing to zero starts once in STOP.
        state_q     <= ST_STOP;
        busy_q      <= 1'b1;
        at_target_q <= 1'b0;
        if ((state_q == ST_STOP) && tick) begin
          vel_q <= vel_step_d;
        end
      end else begin
`else
      begin
`endif
        case (state_q)
          ST_IDLE: begin
            if (tgt_valid && tgt_ready) begin
              tgt_q   <= tgt_vel;
              dwell_q <= tgt_dwell;
              busy_q  <= 1'b1;
              if (tgt_vel == vel_q) begin
                state_q     <= ST_DWELL;
                at_target_q <= 1'b1;
              end else begin
                state_q <= ST_RAMP;
              end
            end
          end
          ST_RAMP: begin
            if (tick) begin
              vel_q <= vel_step_d;
              if (vel_step_d == tgt_q) begin
                state_q     <= ST_DWELL;
                at_target_q <= 1'b1;
              end
            end
          end
          ST_DWELL: begin
            if (done_q) begin
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
              at_target_q <= 1'b0;
            end else if (dwell_q == '0) begin
              done_q <= 1'b1;
            end else if (tick) begin
              dwell_q <= dwell_q - DWELL_W'(1);
            end
          end
`ifdef VELSEQ_ESTOP_EN
          ST_STOP: begin
            if (tick) begin
              vel_q <= vel_step_d;
            end
            if (vel_q == '0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
`endif
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_velocity_sequencer.sv
// Bench for velocity_sequencer: two instances (STEP=1 and STEP=16), TICK_DIV=4.
// Expected outputs come from arithmetic on the command (ramp values, tick counts, dwell length).
module tb_velocity_sequencer;

  localparam int TDIV = 4;

  logic        cclk;
  logic        rstb;
  logic [7:0]  tgt_vel_r   [2];
  logic [15:0] tgt_dwell_r [2];
  logic        tgt_valid_r [2];
  logic        tgt_ready_w [2];
  logic [7:0]  velocity_w  [2];
  logic        at_target_w [2];
  logic        busy_w      [2];
  logic        done_w      [2];
`ifdef VELSEQ_ESTOP_EN
  logic        estop_r     [2];
`endif

  int total = 0;
  int bad   = 0;
  int since_rst = 0;
  int mdl_vel [2];

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  // Edges since the last reset edge; the prescaler phase follows from this.
  always @(posedge cclk) since_rst <= rstb ? since_rst + 1 : 0;

  velocity_sequencer #(.TICK_DIV(TDIV), .STEP(1)) u_dut1 (
    .cclk      (cclk),
    .rstb      (rstb),
    .tgt_vel   (tgt_vel_r[0]),
    .tgt_dwell (tgt_dwell_r[0]),
    .tgt_valid (tgt_valid_r[0]),
`ifdef VELSEQ_ESTOP_EN
    .estop     (estop_r[0]),
`endif
    .tgt_ready (tgt_ready_w[0]),
    .velocity  (velocity_w[0]),
    .at_target (at_target_w[0]),
    .busy      (busy_w[0]),
    .done      (done_w[0])
  );

  velocity_sequencer #(.TICK_DIV(TDIV), .STEP(16)) u_dut16 (
    .cclk      (cclk),
    .rstb      (rstb),
    .tgt_vel   (tgt_vel_r[1]),
    .tgt_dwell (tgt_dwell_r[1]),
    .tgt_valid (tgt_valid_r[1]),
`ifdef VELSEQ_ESTOP_EN
    .estop     (estop_r[1]),
`endif
    .tgt_ready (tgt_ready_w[1]),
    .velocity  (velocity_w[1]),
    .at_target (at_target_w[1]),
    .busy      (busy_w[1]),
    .done      (done_w[1])
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int vel_of(input int u);
    return int'($signed(velocity_w[u]));
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Value after i ramp ticks: linear in STEP, last tick lands on target.
  function automatic int ramp_val(input int v0, input int tv, input int s, input int i, input int n);
    if (i >= n) return tv;
    return (tv > v0) ? v0 + s * i : v0 - s * i;
  endfunction

  task automatic idle_outputs(input string tag, input int u, input int ev, input int erdy);
    chk({tag, "_vel"},   vel_of(u), ev);
    chk({tag, "_busy"},  int'(busy_w[u]), 0);
    chk({tag, "_atgt"},  int'(at_target_w[u]), 0);
    chk({tag, "_done"},  int'(done_w[u]), 0);
    chk({tag, "_ready"}, int'(tgt_ready_w[u]), erdy);
  endtask

  // Issue one command and follow it through to ready; entered and left at a negedge.
  task automatic run_cmd(input string tag, input int u, input int tv, input int dw,
                         input bit keep, input int ntv, input int ndw);
    int s, v0, n, j, k, a_edge, d_edge, guard;
    bit tk;
    s = (u == 0) ? 1 : 16;
    tgt_vel_r[u]   = 8'(tv);
    tgt_dwell_r[u] = 16'(dw);
    tgt_valid_r[u] = 1'b1;
    guard = 0;
    while (tgt_ready_w[u] !== 1'b1 && guard < 3000) begin
      @(negedge cclk);
      guard++;
    end
    chk({tag, "_accept_wait"}, int'(guard < 3000), 1);
    v0 = mdl_vel[u];
    n  = (iabs(tv - v0) + s - 1) / s;
    @(posedge cclk);
    @(negedge cclk);
    if (keep) begin
      tgt_vel_r[u]   = 8'(ntv);
      tgt_dwell_r[u] = 16'(ndw);
    end else begin
      tgt_valid_r[u] = 1'b0;
    end
    k = 0;
    j = 0;
    a_edge = (n == 0) ? 0 : -1;
    d_edge = (n == 0) ? TDIV * dw + 1 : -1;
    while (1) begin
      chk({tag, "_vel"},   vel_of(u), ramp_val(v0, tv, s, k, n));
      chk({tag, "_busy"},  int'(busy_w[u]), int'(d_edge < 0 || j <= d_edge));
      chk({tag, "_atgt"},  int'(at_target_w[u]), int'(a_edge >= 0 && j <= d_edge));
      chk({tag, "_done"},  int'(done_w[u]), int'(j == d_edge));
      chk({tag, "_ready"}, int'(tgt_ready_w[u]), int'(d_edge >= 0 && j > d_edge));
      if (d_edge >= 0 && j > d_edge) break;
      if (j > TDIV * (n + dw) + 16) begin
        chk({tag, "_timeout"}, 0, 1);
        break;
      end
      tk = ((since_rst % TDIV) == TDIV - 1);
      @(posedge cclk);
      j++;
      if (tk && a_edge < 0) begin
        k++;
        if (k == n) begin
          a_edge = j;
          d_edge = j + TDIV * dw + 1;
        end
      end
      @(negedge cclk);
    end
    mdl_vel[u] = tv;
  endtask

  initial begin
    int guard, k, tv, dw, u;
    bit tk;
    rstb = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tgt_vel_r[i]   = '0;
      tgt_dwell_r[i] = '0;
      tgt_valid_r[i] = 1'b0;
      mdl_vel[i]     = 0;
`ifdef VELSEQ_ESTOP_EN
      estop_r[i]     = 1'b0;
`endif
    end

    // Reset held three cycles, then released.
    repeat (3) @(posedge cclk);
    @(negedge cclk);
    idle_outputs("rst1", 0, 0, 0);
    idle_outputs("rst16", 1, 0, 0);
    rstb = 1'b1;
    @(posedge cclk);
    @(negedge cclk);
    chk("rel_ready1", int'(tgt_ready_w[0]), 1);
    chk("rel_ready16", int'(tgt_ready_w[1]), 1);

    // Ramp up by one per tick to +5, dwell two ticks.
    run_cmd("rampup", 0, 5, 2, 1'b0, 0, 0);

`ifdef VELSEQ_ESTOP_EN
    // Estop mid-ramp at 40: hold, slew to zero, ready only after release.
    tgt_vel_r[0] = 8'd60;
    tgt_dwell_r[0] = 16'd0;
    tgt_valid_r[0] = 1'b1;
    @(posedge cclk);
    @(negedge cclk);
    tgt_valid_r[0] = 1'b0;
    guard = 0;
    while (vel_of(0) != 40 && guard < 1000) begin
      @(negedge cclk);
      guard++;
    end
    chk("estop_reach40", int'(guard < 1000), 1);
    estop_r[0] = 1'b1;
    @(posedge cclk);
    @(negedge cclk);
    chk("estop_vel", vel_of(0), 40);
    chk("estop_busy", int'(busy_w[0]), 1);
    chk("estop_atgt", int'(at_target_w[0]), 0);
    k = 0;
    for (int c = 0; c < TDIV * 44; c++) begin
      tk = ((since_rst % TDIV) == TDIV - 1);
      @(posedge cclk);
      if (tk) k++;
      @(negedge cclk);
      chk("estop_slew", vel_of(0), (40 - k > 0) ? 40 - k : 0);
      chk("estop_nodone", int'(done_w[0]), 0);
      chk("estop_noready", int'(tgt_ready_w[0]), 0);
    end
    estop_r[0] = 1'b0;
    @(posedge cclk);
    @(negedge cclk);
    idle_outputs("estop_exit", 0, 0, 1);
    mdl_vel[0] = 0;
`endif

    // Full swing with STEP 16: up to 127, then down to -128 with a clamped last step.
    run_cmd("swing_up", 1, 127, 0, 1'b0, 0, 0);
    run_cmd("swing_dn", 1, -128, 1, 1'b0, 0, 0);

    // Hold-off: -20 held valid while busy, accepted once after done.
    run_cmd("hold_a", 0, 10, 1, 1'b1, -20, 0);
    run_cmd("hold_b", 0, -20, 0, 1'b0, 0, 0);
    repeat (12) @(negedge cclk);
    idle_outputs("hold_once", 0, -20, 1);

    // Random commands on either instance.
    for (int r = 0; r < 8; r++) begin
      u  = int'($urandom_range(1));
      tv = int'($urandom_range(255)) - 128;
      dw = int'($urandom_range(3));
      run_cmd("rand", u, tv, dw, 1'b0, 0, 0);
    end

    // Mid-ramp reset at 17; the old command must not resume.
    run_cmd("to_zero", 0, 0, 0, 1'b0, 0, 0);
    tgt_vel_r[0] = 8'd60;
    tgt_dwell_r[0] = 16'd0;
    tgt_valid_r[0] = 1'b1;
    @(posedge cclk);
    @(negedge cclk);
    tgt_valid_r[0] = 1'b0;
    guard = 0;
    while (vel_of(0) != 17 && guard < 1000) begin
      @(negedge cclk);
      guard++;
    end
    chk("mrst_reach17", int'(guard < 1000), 1);
    rstb = 1'b0;
    @(posedge cclk);
    @(negedge cclk);
    idle_outputs("mrst1", 0, 0, 0);
    idle_outputs("mrst16", 1, 0, 0);
    rstb = 1'b1;
    mdl_vel[0] = 0;
    mdl_vel[1] = 0;
    repeat (20) @(negedge cclk);
    idle_outputs("mrst_noresume", 0, 0, 1);
    run_cmd("post_rst", 1, -3, 0, 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
